panda_top_tb_shell: RTL and testbench
=====================================

Name: panda_top_tb_shell

Overview:
Position-capture (PCAP) arm/capture controller for the PandA top level, driven by the Zynq AXI master through a simple register port. It selects ENABLE and TRIGGER signals from the system bit bus and produces capture strobes, with optional framing mode. It also maintains a sample count, raises a completion interrupt, and exports pcap_armed to the surrounding bench and top level.

Parameters:
SBUS_W, 32, system bit-bus width; selector fields are clog2(SBUS_W) bits.
ADDR_W, 4, register address width.

Ports:
FCLK  in  1  system clock; all logic rising-edge.
ARESETn  in  1  asynchronous active-low reset.
wr_en  in  1  register write strobe, one cycle per write.
wr_addr  in  ADDR_W  write register index.
wr_data  in  32  write data.
rd_en  in  1  register read strobe.
rd_addr  in  ADDR_W  read register index.
rd_data  out  32  read data, valid one cycle after rd_en.
sysbus_i  in  SBUS_W  system bit bus.
capture_o  out  1  one-cycle capture strobe.
frame_o  out  32  FRAMING_MASK while framing enabled and armed, else 0.
irq_o  out  1  one-cycle completion pulse.
pcap_armed  out  1  high while capture is armed.

Behaviour:
- Reset: pcap_armed, capture_o, irq_o = 0; rd_data, frame_o = 0; all registers and counters = 0; state IDLE.
- Register map (write): 0 ARM (any data); 1 DISARM (any data); 2 ENABLE_SEL[4:0]; 3 TRIG_SEL[4:0]; 4 FRAMING_MASK[31:0]; 5 FRAMING_ENABLE[0]; 6 MAX_SAMPLES[31:0] (0 = unlimited).
- Register map (read): 2-6 readback; 7 IRQ_STATUS; 8 SMPL_COUNT[31:0]; others read 0.
- IRQ_STATUS bits: [0] done by enable fall, [1] user disarm, [2] max samples reached, [8] armed, [31:16] SMPL_COUNT[15:0].
- Reading IRQ_STATUS clears bits [2:0] after the read.
- sysbus_i is registered once; enable/trigger edges are detected against the previous registered value, giving 2 cycles of input-to-action latency.
- States:
  - IDLE: ARM write -> ARMED next cycle; pcap_armed=1, SMPL_COUNT cleared, IRQ_STATUS[2:0] cleared, frame-open flag cleared.
  - ARMED: enable (selected bit) high -> ACTIVE. If enable is already high at arm time, go ACTIVE immediately.
  - ACTIVE, trigger rising edge, normal mode: capture_o=1 and SMPL_COUNT++.
  - ACTIVE, trigger rising edge, framing mode: the first edge only sets frame-open; each later edge captures and counts. N edges produce N-1 samples.
  - ACTIVE, enable falling edge: complete with status [0].
- Completion: the next cycle gives pcap_armed=0, irq_o pulse, the status bit set, state IDLE. A capture coincident with the enable fall is suppressed.
- SMPL_COUNT reaching MAX_SAMPLES (nonzero) completes with status [2] on the cycle after the final capture.
- DISARM write in ARMED or ACTIVE completes with status [1]. DISARM in IDLE is ignored, with no irq.
- ARM while armed or active is ignored.
- Simultaneous ARM and DISARM (back-to-back writes) are processed in order. A same-cycle conflict cannot occur because there is a single write port.
- Simultaneous DISARM and trigger edge: DISARM wins, no capture.
- SMPL_COUNT saturates at 0xFFFFFFFF.
- Asynchronous reset mid-capture returns everything to reset values immediately, with no irq.

Test Plan:
- Reset, then ARM: pcap_armed rises 1 cycle after the write. IRQ_STATUS reads 0x00000100.
- ENABLE_SEL=0, TRIG_SEL=1, normal mode; enable high, 5 trigger pulses, enable low -> 5 capture_o pulses, SMPL_COUNT=5, one irq_o pulse, pcap_armed=0, IRQ_STATUS=0x00050001.
- FRAMING_ENABLE=1, FRAMING_MASK=0x0000000F; 6 trigger edges -> 5 captures, frame_o=0x0F while armed and 0 after completion.
- MAX_SAMPLES=3, 10 triggers -> exactly 3 captures, IRQ_STATUS[2]=1, pcap_armed=0.
- ARM then DISARM with no enable -> irq_o pulse, IRQ_STATUS[1]=1. A second IRQ_STATUS read returns [2:0]=0.
- Assert ARESETn low during ACTIVE -> outputs 0 immediately, SMPL_COUNT reads 0 after release.

Source files
------------

// File: rtl/panda_top_tb_shell.sv
// Position-capture arm/capture controller.
// A register port programs the enable/trigger selection, the framing options
// and the sample limit. An FSM arms, captures and completes a run, counting
// samples and raising a one-cycle completion interrupt.
module panda_top_tb_shell #(
    parameter int SBUS_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              FCLK,
    input  logic              ARESETn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic [SBUS_W-1:0] sysbus_i,
    output logic              capture_o,
    output logic [31:0]       frame_o,
    output logic              irq_o,
    output logic              pcap_armed
);

    localparam int SEL_W = $clog2(SBUS_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACTIVE
    } state_t;

    state_t            r_state;
    logic [SBUS_W-1:0] r_sbus;
    logic [SBUS_W-1:0] r_sbusPrev;
    logic [SEL_W-1:0]  r_enableSel;
    logic [SEL_W-1:0]  r_trigSel;
    logic [31:0]       r_frameMask;
    logic              r_frameEn;
    logic [31:0]       r_maxSamples;
    logic [31:0]       r_smplCount;
    logic [2:0]        r_status;
    logic              r_frameOpen;
    logic              r_armed;
    logic              r_capture;
    logic              r_irq;
    logic [31:0]       r_rdData;

    logic              w_enable;
    logic              w_enablePrev;
    logic              w_trig;
    logic              w_trigPrev;
    logic              w_enFall;
    logic              w_trigRise;
    logic              w_armWr;
    logic              w_disarmWr;
    logic              w_statusRd;
    logic              w_maxHit;
    logic [31:0]       w_irqStatus;

    assign w_enable     = r_sbus[r_enableSel];
    assign w_enablePrev = r_sbusPrev[r_enableSel];
    assign w_trig       = r_sbus[r_trigSel];
    assign w_trigPrev   = r_sbusPrev[r_trigSel];
    assign w_enFall     = w_enablePrev && !w_enable;
    assign w_trigRise   = w_trig && !w_trigPrev;
    assign w_armWr      = wr_en && (wr_addr == ADDR_W'(0));
    assign w_disarmWr   = wr_en && (wr_addr == ADDR_W'(1));
    assign w_statusRd   = rd_en && (rd_addr == ADDR_W'(7));
    assign w_maxHit     = (r_maxSamples != 32'd0) && (r_smplCount >= r_maxSamples);
    assign w_irqStatus  = {r_smplCount[15:0], 7'd0, r_armed, 5'd0, r_status};

    assign pcap_armed = r_armed;
    assign capture_o  = r_capture;
    assign irq_o      = r_irq;
    assign rd_data    = r_rdData;
    assign frame_o    = (r_frameEn && r_armed) ? r_frameMask : 32'd0;

    // Register the bit bus once and keep the previous sample for edge detection
    always_ff @(posedge FCLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_sbus     <= '0;
            r_sbusPrev <= '0;
        end else begin
            r_sbus     <= sysbus_i;
            r_sbusPrev <= r_sbus;
        end
    end

    // Configuration registers written from the register port
    always_ff @(posedge FCLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_enableSel  <= '0;
            r_trigSel    <= '0;
            r_frameMask  <= '0;
            r_frameEn    <= 1'b0;
            r_maxSamples <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_W'(2): r_enableSel  <= wr_data[SEL_W-1:0];
                ADDR_W'(3): r_trigSel    <= wr_data[SEL_W-1:0];
                ADDR_W'(4): r_frameMask  <= wr_data;
                ADDR_W'(5): r_frameEn    <= wr_data[0];
                ADDR_W'(6): r_maxSamples <= wr_data;
                default: ;
            endcase
        end
    end

    // Registered read mux; status is sampled here before its sticky bits clear
    always_ff @(posedge FCLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rdData <= '0;
        end else if (rd_en) begin
            case (rd_addr)
                ADDR_W'(2): r_rdData <= {{(32-SEL_W){1'b0}}, r_enableSel};
                ADDR_W'(3): r_rdData <= {{(32-SEL_W){1'b0}}, r_trigSel};
                ADDR_W'(4): r_rdData <= r_frameMask;
                ADDR_W'(5): r_rdData <= {31'd0, r_frameEn};
                ADDR_W'(6): r_rdData <= r_maxSamples;
                ADDR_W'(7): r_rdData <= w_irqStatus;
                ADDR_W'(8): r_rdData <= r_smplCount;
                default:    r_rdData <= '0;
            endcase
        end
    end

    // Arm/capture FSM; disarm beats the sample limit, which beats enable fall, which beats a trigger
    always_ff @(posedge FCLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_capture   <= 1'b0;
            r_irq       <= 1'b0;
            r_smplCount <= '0;
            r_status    <= '0;
            r_frameOpen <= 1'b0;
        end else begin
            r_capture <= 1'b0;
            r_irq     <= 1'b0;
            if (w_statusRd) begin
                r_status <= 3'd0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_armWr) begin
                        r_state     <= w_enable ? S_ACTIVE : S_ARMED;
                        r_armed     <= 1'b1;
                        r_smplCount <= '0;
                        r_status    <= 3'd0;
                        r_frameOpen <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (w_disarmWr) begin
                        r_state     <= S_IDLE;
                        r_armed     <= 1'b0;
                        r_irq       <= 1'b1;
                        r_status[1] <= 1'b1;
                    end else if (w_enable) begin
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_disarmWr) begin
                        r_state     <= S_IDLE;
                        r_armed     <= 1'b0;
                        r_irq       <= 1'b1;
                        r_status[1] <= 1'b1;
                    end else if (w_maxHit) begin
                        r_state     <= S_IDLE;
                        r_armed     <= 1'b0;
                        r_irq       <= 1'b1;
                        r_status[2] <= 1'b1;
                    end else if (w_enFall) begin
                        r_state     <= S_IDLE;
                        r_armed     <= 1'b0;
                        r_irq       <= 1'b1;
                        r_status[0] <= 1'b1;
                    end else if (w_trigRise) begin
                        if (r_frameEn && !r_frameOpen) begin
                            r_frameOpen <= 1'b1;
                        end else begin
                            r_capture <= 1'b1;
                            if (r_smplCount != 32'hFFFF_FFFF) begin
                                r_smplCount <= r_smplCount + 32'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_panda_top_tb_shell.sv
// Directed bench for the position-capture controller.
// Drives the register port and bit bus on falling edges and checks outputs,
// pulse counts and register readbacks against hand-computed values.
module tb_panda_top_tb_shell;

    logic        FCLK;
    logic        ARESETn;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] sysbus_i;
    logic        capture_o;
    logic [31:0] frame_o;
    logic        irq_o;
    logic        pcap_armed;

    int checks = 0;
    int errors = 0;
    int capCount = 0;
    int irqCount = 0;
    int capBase;
    int irqBase;
    logic [31:0] rdVal;

    panda_top_tb_shell #(.SBUS_W(32), .ADDR_W(4)) dut (
        .FCLK       (FCLK),
        .ARESETn    (ARESETn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .sysbus_i   (sysbus_i),
        .capture_o  (capture_o),
        .frame_o    (frame_o),
        .irq_o      (irq_o),
        .pcap_armed (pcap_armed)
    );

    // Free-running system clock
    initial begin
        FCLK = 1'b0;
        forever #5 FCLK = ~FCLK;
    end

    // Count capture and interrupt pulses, sampled mid-cycle
    always @(negedge FCLK) begin
        if (capture_o === 1'b1) capCount++;
        if (irq_o === 1'b1) irqCount++;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Single-cycle register write
    task automatic writeReg(input logic [3:0] addr, input logic [31:0] data);
        @(negedge FCLK);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge FCLK);
        wr_en   = 1'b0;
    endtask

    // Single-cycle register read; data is registered on the edge in between
    task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
        @(negedge FCLK);
        rd_en   = 1'b1;
        rd_addr = addr;
        @(negedge FCLK);
        rd_en   = 1'b0;
        data    = rd_data;
    endtask

    // Drive one bit-bus line to a level
    task automatic applyStimulus(input int bitIdx, input logic level);
        @(negedge FCLK);
        sysbus_i[bitIdx] = level;
    endtask

    // One-cycle trigger pulse followed by two idle cycles
    task automatic pulseTrig(input int bitIdx);
        applyStimulus(bitIdx, 1'b1);
        applyStimulus(bitIdx, 1'b0);
        @(negedge FCLK);
        @(negedge FCLK);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge FCLK);
    endtask

    // Directed test sequence
    initial begin
        ARESETn  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        sysbus_i = '0;

        #12;
        checkOutput("reset_armed",   {31'd0, pcap_armed}, 32'd0);
        checkOutput("reset_capture", {31'd0, capture_o},  32'd0);
        checkOutput("reset_irq",     {31'd0, irq_o},      32'd0);
        checkOutput("reset_frame",   frame_o,             32'd0);
        checkOutput("reset_rddata",  rd_data,             32'd0);
        waitCycles(2);
        ARESETn = 1'b1;
        waitCycles(2);
        readReg(4'd8, rdVal);
        checkOutput("reset_count", rdVal, 32'd0);

        $display("[TB] arm");
        checkOutput("arm_before", {31'd0, pcap_armed}, 32'd0);
        writeReg(4'd0, 32'd0);
        checkOutput("arm_after", {31'd0, pcap_armed}, 32'd1);
        readReg(4'd7, rdVal);
        checkOutput("arm_status", rdVal, 32'h0000_0100);

        $display("[TB] normal capture");
        writeReg(4'd2, 32'd0);
        writeReg(4'd3, 32'd1);
        readReg(4'd3, rdVal);
        checkOutput("trigsel_rb", rdVal, 32'd1);
        capBase = capCount;
        irqBase = irqCount;
        applyStimulus(0, 1'b1);
        waitCycles(3);
        for (int i = 0; i < 5; i++) pulseTrig(1);
        applyStimulus(0, 1'b0);
        waitCycles(4);
        checkOutput("norm_caps",  capCount - capBase, 32'd5);
        checkOutput("norm_irqs",  irqCount - irqBase, 32'd1);
        checkOutput("norm_armed", {31'd0, pcap_armed}, 32'd0);
        readReg(4'd8, rdVal);
        checkOutput("norm_count", rdVal, 32'd5);
        readReg(4'd7, rdVal);
        checkOutput("norm_status", rdVal, 32'h0005_0001);
        readReg(4'd7, rdVal);
        checkOutput("norm_status_clr", rdVal, 32'h0005_0000);

        $display("[TB] framing");
        writeReg(4'd4, 32'h0000_000F);
        writeReg(4'd5, 32'd1);
        readReg(4'd4, rdVal);
        checkOutput("mask_rb", rdVal, 32'h0000_000F);
        checkOutput("frame_idle", frame_o, 32'd0);
        writeReg(4'd0, 32'd0);
        checkOutput("frame_armed", frame_o, 32'h0000_000F);
        capBase = capCount;
        irqBase = irqCount;
        applyStimulus(0, 1'b1);
        waitCycles(3);
        for (int i = 0; i < 6; i++) pulseTrig(1);
        checkOutput("frame_active", frame_o, 32'h0000_000F);
        applyStimulus(0, 1'b0);
        waitCycles(4);
        checkOutput("frame_caps", capCount - capBase, 32'd5);
        checkOutput("frame_irqs", irqCount - irqBase, 32'd1);
        checkOutput("frame_done", frame_o, 32'd0);
        readReg(4'd7, rdVal);
        checkOutput("frame_status", rdVal, 32'h0005_0001);

        $display("[TB] max samples");
        writeReg(4'd5, 32'd0);
        writeReg(4'd6, 32'd3);
        writeReg(4'd0, 32'd0);
        capBase = capCount;
        irqBase = irqCount;
        applyStimulus(0, 1'b1);
        waitCycles(3);
        for (int i = 0; i < 10; i++) pulseTrig(1);
        checkOutput("max_caps",  capCount - capBase, 32'd3);
        checkOutput("max_irqs",  irqCount - irqBase, 32'd1);
        checkOutput("max_armed", {31'd0, pcap_armed}, 32'd0);
        readReg(4'd7, rdVal);
        checkOutput("max_status", rdVal, 32'h0003_0004);
        applyStimulus(0, 1'b0);
        writeReg(4'd6, 32'd0);
        waitCycles(2);

        $display("[TB] disarm");
        irqBase = irqCount;
        writeReg(4'd1, 32'd0);
        waitCycles(2);
        checkOutput("disarm_idle_irq", irqCount - irqBase, 32'd0);
        writeReg(4'd0, 32'd0);
        writeReg(4'd1, 32'd0);
        waitCycles(2);
        checkOutput("disarm_irq",   irqCount - irqBase, 32'd1);
        checkOutput("disarm_armed", {31'd0, pcap_armed}, 32'd0);
        readReg(4'd7, rdVal);
        checkOutput("disarm_status", rdVal, 32'h0000_0002);
        readReg(4'd7, rdVal);
        checkOutput("disarm_status_clr", rdVal, 32'h0000_0000);

        $display("[TB] re-arm ignored and disarm beats trigger");
        writeReg(4'd0, 32'd0);
        capBase = capCount;
        irqBase = irqCount;
        applyStimulus(0, 1'b1);
        waitCycles(3);
        pulseTrig(1);
        pulseTrig(1);
        writeReg(4'd0, 32'd0);
        pulseTrig(1);
        readReg(4'd8, rdVal);
        checkOutput("rearm_count", rdVal, 32'd3);
        applyStimulus(1, 1'b1);
        writeReg(4'd1, 32'd0);
        sysbus_i[1] = 1'b0;
        waitCycles(3);
        checkOutput("race_caps", capCount - capBase, 32'd3);
        checkOutput("race_irqs", irqCount - irqBase, 32'd1);
        readReg(4'd7, rdVal);
        checkOutput("race_status", rdVal, 32'h0003_0002);

        $display("[TB] async reset mid-capture");
        writeReg(4'd0, 32'd0);
        pulseTrig(1);
        readReg(4'd8, rdVal);
        checkOutput("imm_active_count", rdVal, 32'd1);
        irqBase = irqCount;
        @(negedge FCLK);
        ARESETn = 1'b0;
        #1;
        checkOutput("rst_armed", {31'd0, pcap_armed}, 32'd0);
        checkOutput("rst_frame", frame_o,             32'd0);
        checkOutput("rst_cap",   {31'd0, capture_o},  32'd0);
        waitCycles(2);
        ARESETn = 1'b1;
        sysbus_i = '0;
        waitCycles(2);
        checkOutput("rst_irqs", irqCount - irqBase, 32'd0);
        readReg(4'd8, rdVal);
        checkOutput("rst_count", rdVal, 32'd0);
        readReg(4'd3, rdVal);
        checkOutput("rst_trigsel", rdVal, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
